// File: rtl/spi_master_bridge.sv
// ---------------------------------------------------------------------------
// spi_master_bridge
//   SPI initiator that issues 32-bit register frames {rd_wr, addr[14:0],
//   data[15:0]} to the SPI slave register bridge. A valid/ready command is
//   serialised MSB first on MOSI (CPOL=0, slave samples on SCLK rise). Reads
//   insert a SCLK-low turnaround after the address so the slave can fetch the
//   register, then the 16 data bits are shifted in from MISO and returned on
//   a one-cycle response strobe.
//
// Parameters
//   CLK_DIV   : SCLK half-period in spi_clk cycles (>=1)
//   READ_WAIT : SCLK-low cycles between address and data phases of a read
//   CS_GAP    : minimum CS_N-high cycles between frames (>=1)
//
// Ports
//   spi_clk, sys_rst_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake (ready only when idle)
//   cmd_rd_wr/addr/wdata      : command fields (wdata ignored for reads)
//   rsp_valid/rsp_rdata       : read data strobe; rdata held until next read
//   done                      : one-cycle pulse at the end of every frame
//   busy                      : high whenever a frame is in progress
//   spi_cs_n_o/sclk_o/mosi_o  : SPI outputs (all registered)
//   spi_miso_i                : SPI input
// ---------------------------------------------------------------------------
module spi_master_bridge #(
    parameter int CLK_DIV   = 2,
    parameter int READ_WAIT = 32,
    parameter int CS_GAP    = 4
) (
    input  logic        spi_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd_wr,
    input  logic [14:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        done,
    output logic        busy,
    output logic        spi_cs_n_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_DATA, S_HOLD, S_GAP
    } state_t;

    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] WAIT_LAST = 16'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);
    // The IDLE cycle in which the next command is accepted also has CS_N high,
    // so GAP itself lasts one cycle less than the required CS_N-high time.
    localparam logic [15:0] GAP_LAST  = 16'((CS_GAP > 1) ? CS_GAP - 2 : 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic [30:0] tx_q, tx_d;      // bits still to send after the one on MOSI
    logic [15:0] rx_q, rx_d;
    logic        rd_q, rd_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        done_q, done_d;
    logic        half_end;

    assign half_end = (cnt_q == HALF_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rd_d        = rd_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_ADDR;
                    tx_d    = {cmd_addr, (cmd_rd_wr ? 16'h0000 : cmd_wdata)};
                    rd_d    = cmd_rd_wr;
                    mosi_d  = cmd_rd_wr;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_ADDR, S_DATA: begin
                if (!half_end) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Sample MISO on the edge that raises SCLK, before the
                        // slave shifts its next bit out.
                        if (state_q == S_DATA && rd_q)
                            rx_d = {rx_q[14:0], spi_miso_i};
                    end else begin
                        // End of bit: SCLK low again and MOSI advances.
                        sclk_d = 1'b0;
                        mosi_d = tx_q[30];
                        tx_d   = {tx_q[29:0], 1'b0};
                        if (bit_q != 6'd15) begin
                            bit_d = bit_q + 6'd1;
                        end else begin
                            bit_d = '0;
                            if (state_q == S_DATA) begin
                                state_d = S_HOLD;
                                mosi_d  = 1'b0;
                            end else if (rd_q && (READ_WAIT > 0)) begin
                                state_d = S_WAIT;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                    end
                end
            end
            S_WAIT: begin
                // MOSI is already 0 here: the data field of a read is zero.
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (half_end) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    if (rd_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rx_q;
                    end
                    state_d = (CS_GAP > 1) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge spi_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rd_q        <= rd_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign done       = done_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;

endmodule
